// File: rtl/icache_pkg.sv
// icache_pkg: shared fill-state type, cache geometry constants and address-split helpers
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} fill_state_t;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS = 4;
  localparam int NUM_SETS = 8;
  localparam int IDX_LSB = 5;
  localparam int IDX_W = 3;
  localparam int TAG_LSB = 8;
  localparam int TAG_W = 24;
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h1F;
  endfunction
  function automatic logic [IDX_W-1:0] get_index(input logic [31:0] addr);
    return IDX_W'(addr >> IDX_LSB);
  endfunction
  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return TAG_W'(addr >> TAG_LSB);
  endfunction
endpackage

// File: rtl/icache_fill_buffer.sv
// icache_fill_buffer: beat counter plus line buffer that inserts each 64-bit beat at its slot
module icache_fill_buffer
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_en,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [1:0]        beat_cnt,
  output logic [LINE_W-1:0] line
);
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      line <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_en) begin
      line[{beat_cnt, 6'd0} +: BEAT_W] <= beat_data;
      beat_cnt <= beat_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/icache_line_fill.sv
// icache_line_fill: miss-side burst reader that assembles a 256-bit line and writes it in one cycle
// Optional ICACHE_FILL_EARLY_WORD_EN exposes the requested word as soon as its beat arrives.
module icache_line_fill
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [31:0]         miss_addr,
  output logic                fill_busy,
  output logic                fill_done,
`ifdef ICACHE_FILL_EARLY_WORD_EN
  output logic                early_valid,
  output logic [31:0]         early_word,
`endif
  output logic                pmem_read,
  output logic [31:0]         pmem_address,
  input  logic [BEAT_W-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic [31:0]         array_load,
  output logic [IDX_W-1:0]    array_windex,
  output logic [LINE_W-1:0]   array_datain,
  output logic                tag_load,
  output logic [TAG_W-1:0]    tag_out
);
  fill_state_t state, state_n;
  logic [31:0] line_addr;
  logic [1:0] beat_cnt;
  logic accept, beat_en;
  assign accept = state == IDLE && miss_req;
  assign beat_en = state == REQ && pmem_resp;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      line_addr <= '0;
    end else begin
      state <= state_n;
      if (accept) line_addr <= line_align(miss_addr);
    end
  end
  always_comb begin
    state_n = state;
    state_n = accept ? REQ :
              (beat_en && beat_cnt == 2'd3) ? WRITE :
              state == WRITE ? DONE :
              state == DONE ? IDLE : state;
  end
  icache_fill_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .beat_en   (beat_en),
    .beat_data (pmem_rdata),
    .beat_cnt  (beat_cnt),
    .line      (array_datain)
  );
  assign fill_busy = state == REQ || state == WRITE;
  assign fill_done = state == DONE;
  assign pmem_read = state == REQ;
  assign pmem_address = line_addr;
  assign array_load = {32{state == WRITE}};
  assign tag_load = state == WRITE;
  assign array_windex = get_index(line_addr);
  assign tag_out = get_tag(line_addr);
`ifdef ICACHE_FILL_EARLY_WORD_EN
  logic [2:0] word_sel;
  always_ff @(posedge clk) begin
    if (rst) word_sel <= '0;
    else if (accept) word_sel <= miss_addr[4:2];
  end
  // word_sel[2:1] names the beat, word_sel[0] the half within it
  assign early_valid = beat_en && beat_cnt == word_sel[2:1];
  assign early_word = word_sel[0] ? pmem_rdata[63:32] : pmem_rdata[31:0];
`endif
endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill: randomized scoreboard bench for icache_line_fill
module tb_icache_line_fill;
  logic clk = 0, rst = 1, miss_req = 0, pmem_resp = 0;
  logic [31:0] miss_addr = 0;
  logic [63:0] pmem_rdata = 0;
  logic fill_busy, fill_done, pmem_read, tag_load;
  logic [31:0] pmem_address, array_load;
  logic [2:0] array_windex;
  logic [255:0] array_datain;
  logic [23:0] tag_out;
`ifdef ICACHE_FILL_EARLY_WORD_EN
  logic early_valid;
  logic [31:0] early_word;
  logic [31:0] early_q[$];
`endif
  int total = 0, bad = 0;
  logic [63:0] beats[4];
  int gaps[4];
  typedef struct {
    logic [2:0] idx;
    logic [23:0] tag;
    logic [255:0] line;
  } exp_t;
  exp_t exp_q[$];

  icache_line_fill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_busy(fill_busy), .fill_done(fill_done),
`ifdef ICACHE_FILL_EARLY_WORD_EN
    .early_valid(early_valid), .early_word(early_word),
`endif
    .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .array_load(array_load), .array_windex(array_windex),
    .array_datain(array_datain), .tag_load(tag_load), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every array write must match the oldest outstanding fill.
  always @(negedge clk) begin
    if (!rst && (array_load != 0 || tag_load)) begin
      if (exp_q.size() == 0) chk("unexpected_write", 256'(array_load), 256'(0));
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("array_load", 256'(array_load), 256'(32'hFFFF_FFFF));
        chk("tag_load", 256'(tag_load), 256'(1));
        chk("windex", 256'(array_windex), 256'(e.idx));
        chk("tag_out", 256'(tag_out), 256'(e.tag));
        chk("datain", array_datain, e.line);
      end
    end
`ifdef ICACHE_FILL_EARLY_WORD_EN
    if (!rst && early_valid) begin
      if (early_q.size() == 0) chk("unexpected_early", 256'(early_valid), 256'(0));
      else chk("early_word", 256'(early_word), 256'(early_q.pop_front()));
    end
`endif
  end

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pmem_resp = 1'($urandom);
      pmem_rdata = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  task automatic do_fill(input logic [31:0] a);
    exp_t e;
    logic [31:0] align;
    for (int i = 0; i < 4; i++) e.line[i*64 +: 64] = beats[i];
    e.idx = 3'((a >> 5) % 8);
    e.tag = 24'(a >> 8);
    align = a - (a % 32);
    exp_q.push_back(e);
`ifdef ICACHE_FILL_EARLY_WORD_EN
    begin
      int w;
      logic [63:0] b;
      w = int'(a[4:2]);
      b = beats[w / 2];
      early_q.push_back((w % 2) ? b[63:32] : b[31:0]);
    end
`endif
    @(posedge clk); #1;
    miss_req = 1;
    miss_addr = a;
    pmem_resp = 0;
    @(posedge clk); #1;
    miss_addr = $urandom;
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) begin
        pmem_resp = 0;
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("pmem_read_gap", 256'(pmem_read), 256'(1));
        @(posedge clk); #1;
      end
      pmem_resp = 1;
      pmem_rdata = beats[i];
      @(negedge clk);
      chk("pmem_read", 256'(pmem_read), 256'(1));
      chk("pmem_address", 256'(pmem_address), 256'(align));
      chk("fill_busy", 256'(fill_busy), 256'(1));
      @(posedge clk); #1;
    end
    pmem_resp = 0;
    @(negedge clk);
    chk("write_cycle_load", 256'(array_load), 256'(32'hFFFF_FFFF));
    chk("write_cycle_read", 256'(pmem_read), 256'(0));
    chk("write_cycle_busy", 256'(fill_busy), 256'(1));
    @(posedge clk); #1;
    miss_req = 0;
    @(negedge clk);
    chk("fill_done", 256'(fill_done), 256'(1));
    chk("done_busy", 256'(fill_busy), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", 256'(fill_done), 256'(0));
  endtask

  task automatic rand_beats();
    for (int i = 0; i < 4; i++) begin
      beats[i] = {$urandom, $urandom};
      gaps[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 256'(fill_busy), 256'(0));
    chk("rst_done", 256'(fill_done), 256'(0));
    chk("rst_read", 256'(pmem_read), 256'(0));
    chk("rst_addr", 256'(pmem_address), 256'(0));
    chk("rst_load", 256'(array_load), 256'(0));
    chk("rst_datain", array_datain, 256'(0));
    chk("rst_tag", 256'({tag_load, tag_out, array_windex}), 256'(0));
    @(posedge clk); #1;
    rst = 0;
    // basic fill
    beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    gaps = '{0, 0, 0, 0};
    do_fill(32'h0000_1A64);
    // gapped responses
    gaps = '{0, 0, 3, 0};
    do_fill(32'h0000_1A64);
    // reset mid-burst: two beats in, then abort with more beats still arriving
    @(posedge clk); #1;
    miss_req = 1;
    miss_addr = 32'h0000_4218;
    @(posedge clk); #1;
    pmem_resp = 1;
    pmem_rdata = 64'hDEAD_0000_0000_0001;
    @(posedge clk); #1;
    pmem_rdata = 64'hDEAD_0000_0000_0002;
    @(posedge clk); #1;
    rst = 1;
    miss_req = 0;
    pmem_rdata = 64'hDEAD_0000_0000_0003;
    @(posedge clk); #1;
    rst = 0;
    pmem_rdata = 64'hDEAD_0000_0000_0004;
    @(negedge clk);
    chk("abort_read", 256'(pmem_read), 256'(0));
    chk("abort_busy", 256'(fill_busy), 256'(0));
    chk("abort_addr", 256'(pmem_address), 256'(0));
    chk("abort_datain", array_datain, 256'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    pmem_resp = 0;
    @(negedge clk);
    chk("abort_ignore_beats", array_datain, 256'(0));
    rand_beats();
    do_fill(32'h0000_00E0);
    // back-to-back misses
    rand_beats();
    do_fill($urandom);
    rand_beats();
    do_fill($urandom);
    // spurious responses in IDLE
    idle_noise(6);
    rand_beats();
    do_fill(32'h0BAD_F00C);
    // requested word in the upper half of beat 2
    rand_beats();
    do_fill(32'h0000_2014);
    for (int n = 0; n < 20; n++) begin
      idle_noise(int'($urandom_range(0, 4)));
      rand_beats();
      for (int i = 0; i < 4; i++) gaps[i] = int'($urandom_range(0, 3));
      do_fill($urandom);
    end
    repeat (3) @(posedge clk);
    chk("writes_pending", 256'(exp_q.size()), 256'(0));
`ifdef ICACHE_FILL_EARLY_WORD_EN
    chk("early_pending", 256'(early_q.size()), 256'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
